// File: rtl/hamming_dec.sv
// Hamming(21,16) SEC decoder: two-stage pipeline (syndrome, then correct/extract) with valid/ready on both sides.
// Optional macro HAMMING_DEC_CNT_EN adds saturating corrected/uncorrectable word counters.
module hamming_dec #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [20:0]       iData,
  input  logic              iValid,
  output logic              oReady,
  output logic [15:0]       oData,
  output logic              oValid,
  input  logic              iReady,
  output logic              oCorr,
  output logic              oErr,
`ifdef HAMMING_DEC_CNT_EN
  output logic [CNT_W-1:0]  oCorrCnt,
  output logic [CNT_W-1:0]  oErrCnt,
`endif
  output logic [4:0]        oSyndrome
);

  // Bit i of MASK_Sk is set when Hamming position i+1 has bit k set.
  localparam logic [20:0] MASK_S0 = 21'h155555;
  localparam logic [20:0] MASK_S1 = 21'h066666;
  localparam logic [20:0] MASK_S2 = 21'h187878;
  localparam logic [20:0] MASK_S3 = 21'h007F80;
  localparam logic [20:0] MASK_S4 = 21'h1F8000;

  if (CNT_W < 1) begin : g_cnt_w_invalid
  end

  logic        r_s1_valid;
  logic [20:0] r_s1_code;
  logic [4:0]  r_s1_syn;

  logic        r_out_valid;
  logic [15:0] r_out_data;
  logic        r_out_corr;
  logic        r_out_err;
  logic [4:0]  r_out_syn;

  logic        w_stall;
  logic        w_ready;
  logic        w_in_xfer;
  logic        w_out_xfer;
  logic [4:0]  w_syn;
  logic        w_s1_corr;
  logic        w_s1_err;
  logic [20:0] w_flip;
  logic [20:0] w_fixed;
  logic [15:0] w_data;

  assign w_stall    = r_out_valid & ~iReady;
  assign w_ready    = ~r_s1_valid | ~w_stall;
  assign w_in_xfer  = iValid & w_ready;
  assign w_out_xfer = r_out_valid & iReady;

  assign w_syn[0] = ^(iData & MASK_S0);
  assign w_syn[1] = ^(iData & MASK_S1);
  assign w_syn[2] = ^(iData & MASK_S2);
  assign w_syn[3] = ^(iData & MASK_S3);
  assign w_syn[4] = ^(iData & MASK_S4);

  // Syndromes 22..31 point past the codeword; data is passed through raw.
  assign w_s1_corr = (r_s1_syn != 5'd0) && (r_s1_syn <= 5'd21);
  assign w_s1_err  = (r_s1_syn >= 5'd22);
  assign w_flip    = w_s1_corr ? (21'd1 << (r_s1_syn - 5'd1)) : 21'd0;
  assign w_fixed   = r_s1_code ^ w_flip;
  assign w_data    = {w_fixed[20:16], w_fixed[14:8], w_fixed[6:4], w_fixed[2]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_code  <= '0;
      r_s1_syn   <= '0;
    end else if (w_ready) begin
      r_s1_valid <= iValid;
      if (w_in_xfer) begin
        r_s1_code <= iData;
        r_s1_syn  <= w_syn;
      end
    end
  end

  // S2 only updates when not stalled; payload keeps its last value when S1 is empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_corr  <= 1'b0;
      r_out_err   <= 1'b0;
      r_out_syn   <= '0;
    end else if (!w_stall) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_data;
        r_out_corr <= w_s1_corr;
        r_out_err  <= w_s1_err;
        r_out_syn  <= r_s1_syn;
      end
    end
  end

`ifdef HAMMING_DEC_CNT_EN
  logic [CNT_W-1:0] r_corr_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_corr_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (w_out_xfer) begin
      if (r_out_corr && (r_corr_cnt != {CNT_W{1'b1}}))
        r_corr_cnt <= r_corr_cnt + 1'b1;
      if (r_out_err && (r_err_cnt != {CNT_W{1'b1}}))
        r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign oCorrCnt = r_corr_cnt;
  assign oErrCnt  = r_err_cnt;
`else
  logic w_unused;
  assign w_unused = w_out_xfer;
`endif

  assign oReady    = w_ready;
  assign oValid    = r_out_valid;
  assign oData     = r_out_data;
  assign oCorr     = r_out_corr;
  assign oErr      = r_out_err;
  assign oSyndrome = r_out_syn;

endmodule

// File: tb/tb_hamming_dec.sv
// Scoreboard bench for hamming_dec: expectations queued at input handshake, popped by an output monitor.
module tb_hamming_dec;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [20:0] iData = '0;
  logic        iValid = 1'b0;
  logic        iReady = 1'b0;
  logic        oReady;
  logic [15:0] oData;
  logic        oValid;
  logic        oCorr;
  logic        oErr;
  logic [4:0]  oSyndrome;
`ifdef HAMMING_DEC_CNT_EN
  logic [CNT_W-1:0] oCorrCnt;
  logic [CNT_W-1:0] oErrCnt;
`endif

  hamming_dec #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .iData(iData), .iValid(iValid), .oReady(oReady),
    .oData(oData), .oValid(oValid), .iReady(iReady), .oCorr(oCorr), .oErr(oErr),
`ifdef HAMMING_DEC_CNT_EN
    .oCorrCnt(oCorrCnt), .oErrCnt(oErrCnt),
`endif
    .oSyndrome(oSyndrome)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [4:0]  s;
    logic        c;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_corr_cnt = 0;
  int   exp_err_cnt = 0;
  bit   saw_oready_low = 0;
  bit   rand_on = 0;

  // Reference: data fills every non-power-of-two position in ascending order.
  function automatic logic [20:0] encode(input logic [15:0] d);
    logic [20:0] c;
    int j;
    int syn;
    c = '0;
    j = 0;
    for (int p = 1; p <= 21; p++)
      if ((p & (p - 1)) != 0) begin c[p-1] = d[j]; j++; end
    syn = 0;
    for (int p = 1; p <= 21; p++) if (c[p-1]) syn = syn ^ p;
    for (int k = 0; k < 5; k++) c[(1 << k) - 1] = syn[k];
    return c;
  endfunction

  function automatic exp_t model(input logic [20:0] code);
    exp_t r;
    int syn;
    int j;
    logic [20:0] c;
    c = code;
    syn = 0;
    for (int p = 1; p <= 21; p++) if (c[p-1]) syn = syn ^ p;
    r.c = 1'b0;
    r.e = 1'b0;
    if (syn >= 1 && syn <= 21) begin c[syn-1] = ~c[syn-1]; r.c = 1'b1; end
    else if (syn > 21) r.e = 1'b1;
    r.s = syn[4:0];
    r.d = '0;
    j = 0;
    for (int p = 1; p <= 21; p++)
      if ((p & (p - 1)) != 0) begin r.d[j] = c[p-1]; j++; end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per output transfer; also checks stability while stalled.
  exp_t snap;
  bit   have_snap = 0;
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    a = {oData, oSyndrome, oCorr, oErr};
    if (rst && !oReady) saw_oready_low = 1;
    if (rst && oValid && !iReady) begin
      if (have_snap) check("stall_hold", {9'd0, a}, {9'd0, snap});
      snap = a;
      have_snap = 1;
    end else begin
      have_snap = 0;
    end
    if (rst && oValid && iReady) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL word actual d=%h s=%0d c=%b e=%b expected d=%h s=%0d c=%b e=%b at %0t",
                   a.d, a.s, a.c, a.e, e.d, e.s, e.c, e.e, $time);
        end
        if (e.c) exp_corr_cnt++;
        if (e.e) exp_err_cnt++;
      end
    end
  end

  // Callers are aligned to posedge+1; returns aligned to posedge+1 after the accepting edge.
  task automatic send_exp(input logic [20:0] code, input exp_t e);
    int n;
    n = 0;
    iData = code;
    iValid = 1'b1;
    @(negedge clk);
    while (!oReady && n < 100) begin @(negedge clk); n++; end
    if (!oReady) check("send_timeout", 32'd0, 32'd1);
    else exp_q.push_back(e);
    @(posedge clk);
    #1;
    iValid = 1'b0;
  endtask

  task automatic send(input logic [20:0] code);
    send_exp(code, model(code));
  endtask

  task automatic drain();
    int n;
    n = 0;
    iReady = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check("drain_empty", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
`ifdef HAMMING_DEC_CNT_EN
    check({tag, "_corr_cnt"}, 32'(oCorrCnt), 32'(exp_corr_cnt));
    check({tag, "_err_cnt"}, 32'(oErrCnt), 32'(exp_err_cnt));
`else
    check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
`endif
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, "_ovalid"}, 32'(oValid), 32'd0);
    check({tag, "_oready"}, 32'(oReady), 32'd1);
    check({tag, "_odata"}, 32'(oData), 32'd0);
    check({tag, "_osyn"}, 32'(oSyndrome), 32'd0);
    check({tag, "_flags"}, {30'd0, oCorr, oErr}, 32'd0);
`ifdef HAMMING_DEC_CNT_EN
    check({tag, "_cnts"}, 32'(oCorrCnt) | 32'(oErrCnt), 32'd0);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic check_latency(input string tag);
    @(negedge clk);
    check({tag, "_lat_cyc1"}, 32'(oValid), 32'd0);
    @(negedge clk);
    check({tag, "_lat_cyc2"}, 32'(oValid), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [20:0] base;
    logic [20:0] code;
    logic [15:0] d;
    int nf;
    int b0;
    int b1;

    rst = 1'b0;
    iReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    check_reset_state("rst0");

    send_exp(21'h1FFFFE, '{d: 16'hFFFF, s: 5'd0, c: 1'b0, e: 1'b0});
    check_latency("clean");
    send_exp(21'h1FFFDE, '{d: 16'hFFFF, s: 5'd6, c: 1'b1, e: 1'b0});
    send_exp(21'h000001, '{d: 16'h0000, s: 5'd1, c: 1'b1, e: 1'b0});
    send_exp(21'h100002, '{d: 16'h8000, s: 5'd23, c: 1'b0, e: 1'b1});
    base = encode(16'hA5C3);
    for (int i = 0; i < 21; i++) begin
      code = base ^ (21'd1 << i);
      send_exp(code, '{d: 16'hA5C3, s: 5'(i + 1), c: 1'b1, e: 1'b0});
    end
    drain();
    check_counters("directed");

    saw_oready_low = 0;
    fork
      begin
        send(encode(16'h1234));
        send(encode(16'h5678) ^ 21'h000400);
        send(encode(16'h9ABC) ^ 21'h000001);
        send(21'h100002);
        send(encode(16'hDEF0));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        iReady = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        iReady = 1'b1;
      end
    join
    drain();
    check("bp_oready_drop", 32'(saw_oready_low), 32'd1);
    check_counters("bp");

    iReady = 1'b0;
    send(encode(16'h0F0F));
    send(encode(16'hF0F0) ^ 21'h000100);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    exp_corr_cnt = 0;
    exp_err_cnt = 0;
    check_reset_state("rst_mid");
    iReady = 1'b1;
    send_exp(encode(16'h3C3C), '{d: 16'h3C3C, s: 5'd0, c: 1'b0, e: 1'b0});
    check_latency("post_rst");
    drain();
    check_counters("post_rst");

    rand_on = 1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          iReady = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int n = 0; n < 300; n++) begin
          d = 16'($urandom());
          code = encode(d);
          nf = $urandom_range(0, 3);
          b0 = $urandom_range(0, 20);
          b1 = (b0 + $urandom_range(1, 20)) % 21;
          if (nf >= 1) code[b0] = ~code[b0];
          if (nf == 2) code[b1] = ~code[b1];
          if (nf == 3) code = 21'($urandom());
          if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
          send(code);
        end
        rand_on = 0;
      end
    join
    drain();
    check_counters("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hamming_dec.md
Name: hamming_dec

Overview:
- Hamming(21,16) SEC decoder, the receive-side counterpart of the team's Hamming(21,16) encoder.
- Takes a 21-bit codeword and computes the 5-bit syndrome.
- Corrects any single-bit error, extracts the 16 data bits, and flags uncorrectable syndromes.
- Sits between the channel/deserializer and the 16-bit data consumer; valid/ready on both sides.

Parameters:
- CNT_W, 16, width of the error counters (used only with HAMMING_DEC_CNT_EN).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset; logic resets on a clk edge while rst==0.
- iData  in  21  received codeword; index i = Hamming position i+1.
- iValid  in  1  iData valid.
- oReady  out  1  decoder accepts iData this cycle.
- oData  out  16  corrected data word.
- oValid  out  1  oData and flags valid.
- iReady  in  1  consumer accepts output this cycle.
- oCorr  out  1  single-bit error corrected in this word (data or parity bit).
- oErr  out  1  uncorrectable syndrome (22..31).
- oSyndrome  out  5  raw syndrome of this word.
- oCorrCnt  out  CNT_W  corrected-word count (macro only).
- oErrCnt  out  CNT_W  uncorrectable-word count (macro only).

Behaviour:
- Codeword layout:
  - Parity bits at indices 0, 1, 3, 7, 15 (positions 1, 2, 4, 8, 16).
  - Data d[0] at index 2; d[3:1] at indices 6:4; d[10:4] at indices 14:8; d[15:11] at indices 20:16.
- Syndrome: s[k] = XOR of all codeword bits whose position (index+1) has bit k set, k = 0..4. An error-free word gives s = 0.
- Correction:
  - s == 0: no change; oCorr = 0, oErr = 0.
  - 1 ≤ s ≤ 21: invert codeword bit at index s-1, then extract; oCorr = 1.
  - 22 ≤ s ≤ 31: no correction; extract raw data bits; oErr = 1, oCorr = 0.
  - Double errors may alias to s ≤ 21 and miscorrect. This is a known SEC limitation and is not flagged.
- Pipeline: two register stages.
  - S1 captures the codeword and the registered syndrome.
  - S2 holds the corrected data and the flags, which drive the outputs directly from registers.
  - Latency is 2 cycles from the input handshake (iValid & oReady) to oValid, with no stall.
  - Throughput is 1 word per cycle.
- Handshake:
  - stall = oValid & !iReady.
  - oReady = !s1Valid | !stall.
  - Input transfer on iValid & oReady; output transfer on oValid & iReady.
  - While stalled, the S2 registers and outputs hold stable; S1 holds if it is valid.
  - Never drop, duplicate or reorder words. At most 2 words are in flight.
- Simultaneous events:
  - Output transfer and input transfer in the same cycle: S1 advances to S2 and the new word loads S1 in that cycle.
  - Full pipeline with iReady rising: oReady rises in the same cycle, combinationally.
- oData, oCorr, oErr and oSyndrome are meaningful only while oValid = 1; they hold their last values otherwise.
- Reset (rst == 0), including mid-operation:
  - s1Valid = 0, oValid = 0, oData = 0, oCorr = 0, oErr = 0, oSyndrome = 0.
  - In-flight words are discarded.
  - oReady = 1 in the first cycle after reset is released.
- oReady does not depend on iValid, so there is no combinational loop.

Optional Feature:
- Macro: HAMMING_DEC_CNT_EN.
- Defined:
  - oCorrCnt increments on each output transfer with oCorr = 1.
  - oErrCnt increments on each output transfer with oErr = 1.
  - Both counters saturate at 2^CNT_W - 1 and clear to 0 on reset.
- Undefined: the oCorrCnt/oErrCnt ports and all counter logic are absent; the remaining behaviour is unchanged.

Test Plan:
- Clean word: iData = 21'h1FFFFE (encodes 16'hFFFF), iReady = 1 -> two cycles later oValid = 1, oData = 16'hFFFF, oSyndrome = 0, oCorr = 0, oErr = 0.
- Data-bit error: iData = 21'h1FFFDE (index 5 flipped) -> oData = 16'hFFFF, oSyndrome = 6, oCorr = 1, oErr = 0.
- Parity-bit error: iData = 21'h000001 -> oData = 16'h0000, oSyndrome = 1, oCorr = 1; also sweep all 21 single-bit flips of encode(16'hA5C3) -> each gives oData = 16'hA5C3 and oSyndrome = index+1.
- Uncorrectable: iData = 21'h100002 -> oSyndrome = 23, oErr = 1, oCorr = 0, oData = 16'h8000 (uncorrected).
- Backpressure: stream 5 words back-to-back and hold iReady = 0 for cycles 3..6 -> oReady drops once 2 words are held; output holds stable; all 5 words delivered in order with no loss or duplicates; with the macro defined, the counters match the injected error counts.
- Reset mid-stream: drive rst = 0 for one cycle with 2 words in flight -> next cycle oValid = 0, oReady = 1, outputs and counters = 0; a new word then decodes with 2-cycle latency.
